// File: rtl/adc_spi_pkg.sv
// Shared frame/state types and the power-up register table for the ADC16DV160 SPI port.
package adc_spi_pkg;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rsv;
    logic [12:0] addr;
    logic [7:0]  data;
  } adc_spi_frame_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } init_entry_t;

  localparam int unsigned INIT_LEN = 4;

  localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
    '{addr: 13'h0000, data: 8'h24},
    '{addr: 13'h0010, data: 8'h01},
    '{addr: 13'h0013, data: 8'h0A},
    '{addr: 13'h0105, data: 8'h55}
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP
  } state_t;

  // Read frames carry a zero data field.
  function automatic adc_spi_frame_t make_frame(input logic rw, input logic [12:0] addr,
                                                input logic [7:0] data);
    make_frame = '{rw: rw, rsv: 2'b00, addr: addr, data: rw ? 8'h00 : data};
  endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// Bit-level SPI engine: 24-bit MSB-first shift register, SCLK divider and SDO capture.
module adc_spi_shifter
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  adc_spi_frame_t frame,
  input  logic           start,
  output logic           done,
  output logic           sclk,
  output logic           sdi,
  input  logic           sdo,
  output logic [7:0]     rdata
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [23:0] sr_q, sr_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  half_q, half_d;
  logic        active_q, active_d;
  logic        half_end;

  assign half_end = active_q && (div_q == DIV_LAST);

  always_comb begin
    sr_d     = sr_q;
    rx_d     = rx_q;
    div_d    = div_q;
    half_d   = half_q;
    active_d = active_q;
    if (load) begin
      sr_d = frame;
      rx_d = '0;
    end
    if (start) begin
      active_d = 1'b1;
      div_d    = '0;
      half_d   = '0;
    end else if (active_q) begin
      if (half_end) begin
        div_d  = '0;
        half_d = half_q + 6'd1;
        // Even half-periods are SCLK low: their end is the rising edge, odd ends are falling.
        if (!half_q[0]) begin
          rx_d = {rx_q[6:0], sdo};
        end else if (half_q == 6'd47) begin
          active_d = 1'b0;
        end else begin
          sr_d = {sr_q[22:0], 1'b0};
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      rx_q     <= '0;
      div_q    <= '0;
      half_q   <= '0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      rx_q     <= rx_d;
      div_q    <= div_d;
      half_q   <= half_d;
      active_q <= active_d;
    end
  end

  assign done  = half_end && (half_q == 6'd47);
  assign sclk  = active_q && half_q[0];
  assign sdi   = sr_q[23];
  assign rdata = rx_q;

endmodule

// File: rtl/adc_spi_ctrl.sv
// ADC16DV160 SPI configuration controller: init table replay and host register access.
// Define ADC_SPI_READBACK_EN to follow every init write with a verifying read frame.
module adc_spi_ctrl
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          AUTO_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_sdi,
  input  logic        spi_sdo
);
  localparam int unsigned      IDX_W    = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_LEN - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             boot_q;
  logic             init_pend_q, init_pend_d;
  logic             host_q, host_d;
  logic             rw_q, rw_d;
  logic             init_done_q, init_done_d;
  logic             last_cnt, init_req, advance;
  logic             sh_load, sh_start, sh_done, sh_sclk, sh_sdi;
  logic [7:0]       sh_rdata;
  adc_spi_frame_t   sh_frame;
`ifdef ADC_SPI_READBACK_EN
  logic             rb_q, rb_d;
  logic             init_err_q, init_err_d;
`endif

  assign last_cnt  = (cnt_q == DIV_LAST);
  // boot_q stays low for the first cycle out of reset to raise the auto-init request.
  assign init_req  = init_start || (AUTO_INIT && !boot_q);
  assign req_ready = (state_q == ST_IDLE) && boot_q && !init_pend_q && !init_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rsp_rdata_d = rsp_rdata_q;
    init_pend_d = init_pend_q;
    host_d      = host_q;
    rw_d        = rw_q;
    init_done_d = init_done_q;
    sh_load     = 1'b0;
    sh_start    = 1'b0;
    advance     = 1'b0;
`ifdef ADC_SPI_READBACK_EN
    rb_d       = rb_q;
    init_err_d = init_err_q;
    sh_frame   = make_frame(rb_q, INIT_TABLE[idx_q].addr, INIT_TABLE[idx_q].data);
`else
    sh_frame   = make_frame(1'b0, INIT_TABLE[idx_q].addr, INIT_TABLE[idx_q].data);
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (init_pend_q) begin
          sh_load = 1'b1;
          host_d  = 1'b0;
          rw_d    = sh_frame.rw;
          state_d = ST_CS_SETUP;
        end else if (init_req) begin
          init_pend_d = 1'b1;
          idx_d       = '0;
          init_done_d = 1'b0;
`ifdef ADC_SPI_READBACK_EN
          rb_d       = 1'b0;
          init_err_d = 1'b0;
`endif
        end else if (req_valid && req_ready) begin
          sh_frame = make_frame(req_rw, req_addr, req_wdata);
          sh_load  = 1'b1;
          host_d   = 1'b1;
          rw_d     = req_rw;
          state_d  = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (last_cnt) begin
          cnt_d    = '0;
          sh_start = 1'b1;
          state_d  = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          cnt_d   = '0;
          state_d = ST_CS_HOLD;
          if (host_q) begin
            rsp_rdata_d = rw_q ? sh_rdata : 8'h00;
          end
`ifdef ADC_SPI_READBACK_EN
          else if (rw_q && (sh_rdata != INIT_TABLE[idx_q].data)) begin
            init_err_d = 1'b1;
          end
`endif
        end
      end
      ST_CS_HOLD: begin
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
`ifdef ADC_SPI_READBACK_EN
          if (!host_q) begin
            rb_d    = !rb_q;
            advance = rb_q;
          end
`else
          advance = !host_q;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance) begin
      if (idx_q == IDX_LAST) begin
        idx_d       = '0;
        init_pend_d = 1'b0;
        init_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rsp_rdata_q <= '0;
      boot_q      <= 1'b0;
      init_pend_q <= 1'b0;
      host_q      <= 1'b0;
      rw_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rsp_rdata_q <= rsp_rdata_d;
      boot_q      <= 1'b1;
      init_pend_q <= init_pend_d;
      host_q      <= host_d;
      rw_q        <= rw_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef ADC_SPI_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_q       <= 1'b0;
      init_err_q <= 1'b0;
    end else begin
      rb_q       <= rb_d;
      init_err_q <= init_err_d;
    end
  end
  assign init_err = init_err_q;
`else
  assign init_err = 1'b0;
`endif

  adc_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk  (clk),
    .rst_n(rst_n),
    .load (sh_load),
    .frame(sh_frame),
    .start(sh_start),
    .done (sh_done),
    .sclk (sh_sclk),
    .sdi  (sh_sdi),
    .sdo  (spi_sdo),
    .rdata(sh_rdata)
  );

  assign spi_cs_n  = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign spi_sclk  = sh_sclk;
  assign spi_sdi   = !spi_cs_n && sh_sdi;
  assign busy      = (state_q != ST_IDLE) || init_pend_q;
  assign init_done = init_done_q;
  assign rsp_valid = (state_q == ST_GAP) && last_cnt && host_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// Directed bench for adc_spi_ctrl with a behavioural ADC16DV160 serial-port model.
module tb_adc_spi_ctrl;
  import adc_spi_pkg::*;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned FRAME_CYC = 51 * CLK_DIV;
`ifdef ADC_SPI_READBACK_EN
  localparam int unsigned FR_PER_ENTRY = 2;
`else
  localparam int unsigned FR_PER_ENTRY = 1;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        init_start = 1'b0, req_valid = 1'b0, req_rw = 1'b0;
  logic [12:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, busy, init_done, init_err;
  logic        spi_cs_n, spi_sclk, spi_sdi, spi_sdo;
  logic [7:0]  rsp_rdata;

  always #5 clk = ~clk;

  adc_spi_ctrl #(.CLK_DIV(CLK_DIV), .AUTO_INIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .init_done(init_done), .init_err(init_err),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo)
  );

  int errors = 0, checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ADC serial port model ----------------
  logic [7:0]  mem [8192];
  logic [23:0] m_sh = '0;
  int          m_bits = 0;
  logic        m_act = 1'b0;
  logic [7:0]  m_rd = '0;
  logic [23:0] fq [$];
  int          aborts = 0, sclk_bad = 0;
  logic        corrupt_en = 1'b0;
  logic [12:0] corrupt_addr = '0;
  logic        sdo_r = 1'b0;
  assign spi_sdo = sdo_r;

  always @(negedge spi_cs_n) begin
    m_act = 1'b1; m_bits = 0; m_sh = '0;
  end
  always @(posedge spi_sclk) begin
    if (spi_cs_n) sclk_bad++;
    else begin
      m_sh = {m_sh[22:0], spi_sdi};
      m_bits++;
      if (m_bits == 16) m_rd = mem[m_sh[12:0]];
    end
  end
  always @(negedge spi_sclk) begin
    if (!spi_cs_n && m_bits >= 16 && m_bits < 24) sdo_r = m_rd[23 - m_bits];
  end
  always @(posedge spi_cs_n) begin
    if (m_act) begin
      m_act = 1'b0;
      if (m_bits == 24) begin
        fq.push_back(m_sh);
        if (!m_sh[23])
          mem[m_sh[20:8]] = (corrupt_en && m_sh[20:8] == corrupt_addr) ? ~m_sh[7:0] : m_sh[7:0];
      end else begin
        aborts++;
      end
    end
  end

  // cs_n low time must always be setup + 48 half-periods + hold
  logic        cs_prev = 1'b1, chk_len = 1'b1;
  int unsigned fall_cyc = 0;
  always @(negedge clk) begin
    if (!spi_cs_n && cs_prev) fall_cyc = cyc;
    if (spi_cs_n && !cs_prev && chk_len) check("cs_low_len", cyc - fall_cyc, 50 * CLK_DIV);
    cs_prev = spi_cs_n;
  end

  // ---------------- sequences ----------------
  task automatic run_init(input logic exp_err);
    int base, n;
    base = fq.size();
    n = 0;
    while (!init_done && n < INIT_LEN * FR_PER_ENTRY * (FRAME_CYC + 4) + 100) begin
      @(negedge clk); n++;
    end
    check("init_done", init_done, 1);
    check("init_busy_clr", busy, 0);
    check("init_err", init_err, exp_err);
    check("init_frames", fq.size() - base, INIT_LEN * FR_PER_ENTRY);
    if (fq.size() >= base + INIT_LEN * FR_PER_ENTRY) begin
      for (int i = 0; i < INIT_LEN; i++) begin
        check("init_wr_frame", fq[base + i * FR_PER_ENTRY],
              {1'b0, 2'b00, INIT_TABLE[i].addr, INIT_TABLE[i].data});
`ifdef ADC_SPI_READBACK_EN
        check("init_rb_frame", fq[base + i * 2 + 1], {1'b1, 2'b00, INIT_TABLE[i].addr, 8'h00});
`endif
      end
    end
  endtask

  task automatic pulse_init();
    @(negedge clk); init_start = 1'b1;
    @(negedge clk); init_start = 1'b0;
    check("init_start_clr_done", init_done, 0);
    check("init_start_busy", busy, 1);
  endtask

  task automatic do_req(input logic rw, input logic [12:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input string tag);
    int n, base;
    base = fq.size();
    @(negedge clk);
    req_rw = rw; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    check({tag, "_ready"}, req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < FRAME_CYC + 50) begin @(negedge clk); n++; end
    check({tag, "_rsp"}, rsp_valid, 1);
    check({tag, "_len"}, cyc - fall_cyc + 1, FRAME_CYC);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_nframes"}, fq.size() - base, 1);
    if (fq.size() > base)
      check({tag, "_frame"}, fq[fq.size() - 1], {rw, 2'b00, addr, rw ? 8'h00 : wd});
    @(negedge clk);
    check({tag, "_pulse"}, rsp_valid, 0);
  endtask

  typedef struct {
    logic        rw;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int n, base, ab0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[2] = 8'hA5;
    vecs[0] = '{1'b0, 13'h0011, 8'h3C, 8'h00};
    vecs[1] = '{1'b1, 13'h0002, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 13'h0011, 8'h00, 8'h3C};
    vecs[3] = '{1'b0, 13'h1FFF, 8'hFF, 8'h00};
    vecs[4] = '{1'b1, 13'h1FFF, 8'h5A, 8'hFF};
    vecs[5] = '{1'b1, 13'h0010, 8'h00, 8'h01};

    repeat (3) @(negedge clk);
    check("rst_outputs", {spi_cs_n, spi_sclk, spi_sdi, req_ready, rsp_valid, busy, init_done, init_err},
          8'b1000_0000);
    check("rst_rdata", rsp_rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check("auto_init_busy", busy, 1);
    run_init(1'b0);

    for (int i = 0; i < 6; i++)
      do_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, $sformatf("host%0d", i));

    // init_start and req_valid together: init owns the bus first
    @(negedge clk);
    init_start = 1'b1; req_valid = 1'b1; req_rw = 1'b0; req_addr = 13'h0020; req_wdata = 8'h77;
    #1;
    check("cont_ready_low", req_ready, 0);
    base = fq.size();
    @(negedge clk); init_start = 1'b0;
    check("cont_done_clr", init_done, 0);
    n = 0;
    while (!req_ready && n < INIT_LEN * FR_PER_ENTRY * (FRAME_CYC + 4) + 100) begin
      @(negedge clk); n++;
    end
    check("cont_ready", req_ready, 1);
    check("cont_done_at_ready", init_done, 1);
    check("cont_frames_before", fq.size() - base, INIT_LEN * FR_PER_ENTRY);
    if (fq.size() > base)
      check("cont_first_is_init", fq[base], {1'b0, 2'b00, INIT_TABLE[0].addr, INIT_TABLE[0].data});
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < FRAME_CYC + 50) begin @(negedge clk); n++; end
    check("cont_rsp", rsp_valid, 1);
    if (fq.size() > base)
      check("cont_host_frame", fq[fq.size() - 1], {1'b0, 2'b00, 13'h0020, 8'h77});

    // asynchronous reset in the middle of a host write
    ab0 = aborts;
    @(negedge clk);
    req_rw = 1'b0; req_addr = 13'h0055; req_wdata = 8'h99; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    while (!(m_act && m_bits == 10) && n < FRAME_CYC) begin @(negedge clk); n++; end
    check("abort_at_10", m_bits, 10);
    chk_len = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_done", init_done, 0);
    check("abort_seen", aborts - ab0, 1);
    check("abort_no_commit", mem[13'h0055], 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_len = 1'b1;
    run_init(1'b0);

`ifdef ADC_SPI_READBACK_EN
    corrupt_en = 1'b1; corrupt_addr = INIT_TABLE[1].addr;
    pulse_init();
    run_init(1'b1);
    corrupt_en = 1'b0;
    pulse_init();
    run_init(1'b0);
`else
    pulse_init();
    run_init(1'b0);
`endif

    check("no_sclk_while_cs_high", sclk_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/adc_spi_ctrl.md
Name: adc_spi_ctrl

Overview:
- SPI configuration controller for the ADC16DV160 serial control port (SCSb/SCLK/SDI/SDO, 4-wire).
- After reset it replays a fixed init register table into the ADC, then serves single host register read/write requests.
- It is the sole owner of the ADC SPI bus and arbitrates between the internal init sequencer and the host port.
- Sits beside the LVDS capture path; capture logic waits for init_done before trusting ADC data.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255.
- AUTO_INIT, 1, 1 = start the init sequence automatically after reset; 0 = wait for init_start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  one-cycle pulse that (re)starts the init table; ignored while busy
- req_valid  in  1  host request valid
- req_ready  out  1  host request accepted when req_valid && req_ready
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  13  ADC register address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse at the end of each host transaction
- rsp_rdata  out  8  read data; 0 for writes
- busy  out  1  a frame or the init sequence is in progress
- init_done  out  1  init table has completed; sticky until reset or init_start
- init_err  out  1  readback mismatch (see Optional Feature)
- spi_cs_n  out  1  ADC SCSb
- spi_sclk  out  1  ADC SCLK, idle low
- spi_sdi  out  1  data to ADC
- spi_sdo  in  1  data from ADC

Behaviour:
- Reset values: spi_cs_n=1, spi_sclk=0, spi_sdi=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, init_done=0, init_err=0. Table index=0.
- Frame is 24 bits, MSB first: {rw, 2'b00, addr[12:0], data[7:0]}. For reads the data field is sent as 0.
- SDI changes at the start of the SCLK low phase. ADC samples SDI on the rising edge. The controller samples SDO in the clk cycle where spi_sclk goes 0->1; for a read, the last 8 samples form rdata.
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> IDLE.
  - IDLE: if an init request is pending, load the next table entry; else if req_valid, load the host request.
  - CS_SETUP: cs_n=0 for CLK_DIV cycles; bit 23 is driven on SDI.
  - SHIFT: 48 half-periods of CLK_DIV cycles each.
  - CS_HOLD: sclk=0, cs_n still 0, for CLK_DIV cycles.
  - GAP: cs_n=1 for CLK_DIV cycles.
  - Frame length is exactly 51*CLK_DIV clk cycles, measured from cs_n falling to the return to IDLE.
- req_ready=1 only in IDLE when no init is pending. A request is captured on the handshake. rsp_valid pulses in the cycle GAP exits to IDLE.
- Init sequence:
  - Pending after reset (AUTO_INIT=1) or after an init_start pulse seen in IDLE.
  - Runs INIT_LEN frames back to back with no host interleave.
  - init_done is set in the cycle the last frame's GAP ends.
  - init_start clears init_done and init_err.
- Arbitration: on a simultaneous init_start and req_valid in IDLE, init wins and req_ready stays 0.
- Asynchronous reset mid-frame: the frame is aborted and all outputs return to reset values immediately. The init sequence restarts from index 0 if AUTO_INIT=1.
- busy = (state != IDLE) || init pending.

Optional Feature:
- Macro ADC_SPI_READBACK_EN.
- Defined:
  - Each init write is followed by a read frame to the same address.
  - If the read data differs from the written data, init_err is set (sticky); the sequence still completes.
  - Init takes 2*INIT_LEN frames.
- Undefined: no readback frames; init_err is tied to 0.

Decomposition:
- Package adc_spi_pkg holds:
  - typedef adc_spi_frame_t (packed rw/rsv/addr/data);
  - INIT_LEN;
  - the INIT_TABLE constant array of {addr, data} pairs;
  - the state enum.
- Sub-module adc_spi_shifter handles the bit level: the 24-bit shift register, the SCLK divider and the SDO capture, with a start/done handshake. adc_spi_ctrl keeps the sequencing and arbitration.

Test Plan:
- Reset check: hold rst_n=0 -> all outputs at reset values; release with AUTO_INIT=1, CLK_DIV=4 -> INIT_LEN frames of exactly 204 clk cycles each, captured addr/data match INIT_TABLE, then init_done=1.
- Host write: addr=0x0011, wdata=0x3C after init -> ADC model decodes 0x00113C MSB first, no SCLK edge while cs_n=1, and rsp_valid pulses once with rdata=0.
- Host read: ADC model returns 0xA5 at addr 0x0002 -> rsp_rdata=0xA5.
- Contention: init_start and req_valid asserted in the same cycle -> req_ready stays 0 until the whole init sequence completes, then the host request is served.
- Reset mid-frame: assert rst_n=0 after 10 SCLK rising edges -> cs_n=1 and sclk=0 the same cycle, and the ADC model sees an aborted, not committed, frame.
- Readback mismatch (ADC_SPI_READBACK_EN defined): model corrupts one init register -> init_err=1, init_done=1, 2*INIT_LEN frames observed.
